dtc_req_scheduler: RTL and testbench

- Shares one combinational 12-in/3-out decision-tree classifier between NUM_REQ requesters.
- Round-robin arbitration picks one requester, registers its feature vector onto the classifier input, and waits EVAL_CYCLES for the tree to settle.
- It then captures the class, tags it with the requester ID, and presents it on a valid/ready result port.
- Sits between feature producers and the classifier instance in the inference datapath.

---
 rtl/dtc_req_scheduler.sv | 112 +++++++++++
 tb/tb_dtc_req_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_req_scheduler.sv
// dtc_req_scheduler: round-robin sharing of one combinational classifier between requesters
module dtc_req_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int IN_W        = 12,
  parameter int OUT_W       = 3,
  parameter int ID_W        = 2,
  parameter int EVAL_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [IN_W-1:0]         cls_inp,
  input  logic [OUT_W-1:0]        cls_outp,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [OUT_W-1:0]        res_class,
  output logic [ID_W-1:0]         res_id,
  output logic                    busy,
  output logic [15:0]             done_cnt
);
  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;
  state_t            state_q, state_d;
  logic [IN_W-1:0]   cls_inp_q, cls_inp_d;
  logic [ID_W-1:0]   id_q, id_d, last_grant_q, last_grant_d, res_id_q, res_id_d, grant;
  logic [OUT_W-1:0]  res_class_q, res_class_d;
  logic              res_valid_q, res_valid_d, found;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       done_cnt_q, done_cnt_d;
  // round-robin search starting just after the last accepted requester
  always_comb begin
    int idx;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end
  // next-state and outputs: accept in IDLE, count down in EVAL, present result in HOLD
  always_comb begin
    state_d      = state_q;
    cls_inp_d    = cls_inp_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    res_class_d  = res_class_q;
    res_id_d     = res_id_q;
    res_valid_d  = res_valid_q;
    done_cnt_d   = done_cnt_q;
    req_ready    = '0;
    case (state_q)
      IDLE: if (found) begin
        req_ready[grant] = 1'b1;
        cls_inp_d        = req_data[grant*IN_W +: IN_W];
        id_d             = grant;
        last_grant_d     = grant;
        cnt_d            = 4'(EVAL_CYCLES);
        state_d          = EVAL;
      end
      EVAL: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          res_class_d = cls_outp;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: if (res_ready) begin
        res_valid_d = 1'b0;
        done_cnt_d  = (done_cnt_q == 16'hFFFF) ? done_cnt_q : done_cnt_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cls_inp_q    <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      res_class_q  <= '0;
      res_id_q     <= '0;
      res_valid_q  <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cls_inp_q    <= cls_inp_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      res_class_q  <= res_class_d;
      res_id_q     <= res_id_d;
      res_valid_q  <= res_valid_d;
      done_cnt_q   <= done_cnt_d;
    end
  end
  assign cls_inp   = cls_inp_q;
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);
  assign done_cnt  = done_cnt_q;
endmodule

// File: tb/tb_dtc_req_scheduler.sv
// tb_dtc_req_scheduler: vector table, corner sequences and random run against a transaction model
module tb_dtc_req_scheduler;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [3:0]  rv1 = '0, rdy1, rv4 = '0, rdy4;
  logic [47:0] data1 = '0, data4 = '0;
  logic [11:0] inp1, inp4;
  logic [2:0]  outp1, outp4, rc1, rc4;
  logic        vld1, vld4, rr1 = 1'b0, rr4 = 1'b0, bsy1, bsy4, tog = 1'b0;
  logic [1:0]  rid1, rid4;
  logic [15:0] done1, done4;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  assign outp1 = inp1[2:0];
  assign outp4 = inp4[2:0] ^ {3{tog}};

  dtc_req_scheduler #(.NUM_REQ(4), .IN_W(12), .OUT_W(3), .ID_W(2), .EVAL_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_ready(rdy1), .req_data(data1),
    .cls_inp(inp1), .cls_outp(outp1), .res_valid(vld1), .res_ready(rr1),
    .res_class(rc1), .res_id(rid1), .busy(bsy1), .done_cnt(done1));

  dtc_req_scheduler #(.NUM_REQ(4), .IN_W(12), .OUT_W(3), .ID_W(2), .EVAL_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_ready(rdy4), .req_data(data4),
    .cls_inp(inp4), .cls_outp(outp4), .res_valid(vld4), .res_ready(rr4),
    .res_class(rc4), .res_id(rid4), .busy(bsy4), .done_cnt(done4));

  typedef struct {
    int rv, d0, rdy, vld, cls, id, bsy, done;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; rv1 = '0; rr1 = 1'b0; rv4 = '0; rr4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int g, j, m_last, m_acc, m_id, cyc;
    bit m_idle;
    logic [11:0] m_inp;
    logic [2:0] m_rc;
    logic [1:0] m_rid;
    logic [15:0] m_done;
    logic exp_vld;
    // rv, d0, rdy, vld, cls, id, busy, done
    tv.push_back('{'h1, 'hA5C, 'h1, 0, 0, 0, 0, 0});
    tv.push_back('{'h0, 'hA5C, 'h0, 0, 0, 0, 1, 0});
    tv.push_back('{'h0, 'hA5C, 'h0, 1, 4, 0, 1, 0});
    tv.push_back('{'hF, 'h001, 'h2, 0, 4, 0, 0, 1});
    tv.push_back('{'hF, 'h001, 'h0, 0, 4, 0, 1, 1});
    tv.push_back('{'hF, 'h001, 'h0, 1, 2, 1, 1, 1});
    tv.push_back('{'hF, 'h001, 'h4, 0, 2, 1, 0, 2});
    tv.push_back('{'hF, 'h001, 'h0, 0, 2, 1, 1, 2});
    tv.push_back('{'hF, 'h001, 'h0, 1, 3, 2, 1, 2});
    tv.push_back('{'hF, 'h001, 'h8, 0, 3, 2, 0, 3});
    tv.push_back('{'hF, 'h001, 'h0, 0, 3, 2, 1, 3});
    tv.push_back('{'hF, 'h001, 'h0, 1, 4, 3, 1, 3});
    tv.push_back('{'hF, 'h001, 'h1, 0, 4, 3, 0, 4});
    tv.push_back('{'hF, 'h001, 'h0, 0, 4, 3, 1, 4});
    tv.push_back('{'hF, 'h001, 'h0, 1, 1, 0, 1, 4});
    tv.push_back('{'hA, 'h001, 'h2, 0, 1, 0, 0, 5});
    tv.push_back('{'hA, 'h001, 'h0, 0, 1, 0, 1, 5});
    tv.push_back('{'hA, 'h001, 'h0, 1, 2, 1, 1, 5});
    tv.push_back('{'hA, 'h001, 'h8, 0, 2, 1, 0, 6});
    tv.push_back('{'hA, 'h001, 'h0, 0, 2, 1, 1, 6});
    tv.push_back('{'hA, 'h001, 'h0, 1, 4, 3, 1, 6});
    tv.push_back('{'hA, 'h001, 'h2, 0, 4, 3, 0, 7});
    tv.push_back('{'h0, 'h001, 'h0, 0, 4, 3, 1, 7});
    tv.push_back('{'h0, 'h001, 'h0, 1, 2, 1, 1, 7});
    tv.push_back('{'h0, 'h001, 'h0, 0, 2, 1, 0, 8});

    do_reset();
    #1;
    chk("rst_busy", bsy1, 0);
    chk("rst_valid", vld1, 0);
    chk("rst_ready", rdy1, 0);
    chk("rst_inp", inp1, 0);
    chk("rst_done", done1, 0);
    chk("rst_class", rc1, 0);
    chk("rst_id", rid1, 0);

    foreach (tv[i]) begin
      @(negedge clk);
      rv1 = 4'(tv[i].rv);
      rr1 = 1'b1;
      data1 = {12'h004, 12'h003, 12'h002, 12'(tv[i].d0)};
      #1;
      chk($sformatf("row%0d_ready", i), rdy1, tv[i].rdy);
      chk($sformatf("row%0d_valid", i), vld1, tv[i].vld);
      chk($sformatf("row%0d_class", i), rc1, tv[i].cls);
      chk($sformatf("row%0d_id", i), rid1, tv[i].id);
      chk($sformatf("row%0d_busy", i), bsy1, tv[i].bsy);
      chk($sformatf("row%0d_done", i), done1, tv[i].done);
    end

    // backpressure: grant requester 2, stall the result for 5 HOLD cycles
    @(negedge clk);
    rv1 = 4'b0100; rr1 = 1'b0;
    #1 chk("bp_ready", rdy1, 4'b0100);
    @(negedge clk);
    rv1 = 4'b1111;
    #1 chk("bp_eval_busy", bsy1, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", vld1, 1);
      chk("bp_class", rc1, 3);
      chk("bp_id", rid1, 2);
      chk("bp_ready_low", rdy1, 0);
      chk("bp_busy", bsy1, 1);
    end
    @(negedge clk);
    rr1 = 1'b1;
    #1 chk("bp_release_valid", vld1, 1);
    @(negedge clk);
    rv1 = 4'b0000;
    #1;
    chk("bp_after_valid", vld1, 0);
    chk("bp_after_busy", bsy1, 0);
    chk("bp_after_done", done1, 9);

    // reset during EVAL discards the request and restarts round-robin at 0
    @(negedge clk);
    rv1 = 4'b0100;
    #1 chk("mr_ready", rdy1, 4'b0100);
    @(negedge clk);
    rv1 = 4'b0000; rst_n = 1'b0;
    #1 chk("mr_in_eval", bsy1, 1);
    @(negedge clk);
    rst_n = 1'b1; rv1 = 4'b1111;
    #1;
    chk("mr_valid", vld1, 0);
    chk("mr_busy", bsy1, 0);
    chk("mr_done", done1, 0);
    chk("mr_first_grant", rdy1, 4'b0001);

    // EVAL_CYCLES=4: only the classifier value on the last EVAL cycle is captured
    do_reset();
    rv4 = 4'b0001; data4 = {36'h0, 12'h005}; rr4 = 1'b0; tog = 1'b0;
    #1 chk("lat_ready", rdy4, 4'b0001);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rv4 = 4'b0000;
      tog = (k != 4) ? k[0] : 1'b0;
      #1;
      chk($sformatf("lat_eval%0d_valid", k), vld4, 0);
      chk($sformatf("lat_eval%0d_busy", k), bsy4, 1);
    end
    @(negedge clk);
    tog = 1'b1; rr4 = 1'b1;
    #1;
    chk("lat_valid", vld4, 1);
    chk("lat_class", rc4, 3'd5);
    chk("lat_id", rid4, 0);
    @(negedge clk);
    #1;
    chk("lat_done", done4, 1);
    chk("lat_idle", bsy4, 0);

    // randomized run against a transaction-level model
    do_reset();
    m_idle = 1; m_last = 3; m_acc = 0; m_id = 0; cyc = 0;
    m_inp = '0; m_rc = '0; m_rid = '0; m_done = '0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rv1 = 4'($urandom);
      data1 = 48'({$urandom(), $urandom()});
      rr1 = ($urandom_range(0, 3) != 0);
      #1;
      g = -1;
      if (m_idle)
        for (int k = 1; k <= 4; k++) begin
          j = (m_last + k) % 4;
          if (g < 0 && rv1[j[1:0]]) g = j;
        end
      exp_vld = !m_idle && (cyc - m_acc > 1);
      chk("rnd_ready", rdy1, (g >= 0) ? (1 << g) : 0);
      chk("rnd_valid", vld1, exp_vld);
      chk("rnd_busy", bsy1, !m_idle);
      chk("rnd_class", rc1, m_rc);
      chk("rnd_id", rid1, m_rid);
      chk("rnd_done", done1, m_done);
      chk("rnd_inp", inp1, m_inp);
      if (g >= 0) begin
        m_idle = 0; m_acc = cyc; m_id = g; m_last = g;
        m_inp = data1[g*12 +: 12];
      end else if (!m_idle && cyc - m_acc == 1) begin
        m_rc = m_inp[2:0]; m_rid = 2'(m_id);
      end else if (exp_vld && rr1) begin
        m_idle = 1;
        if (m_done != 16'hFFFF) m_done = m_done + 16'd1;
      end
      cyc++;
    end

    // completion counter saturation
    do_reset();
    force u1.done_cnt_q = 16'hFFFE;
    @(negedge clk);
    release u1.done_cnt_q;
    #1 chk("sat_preload", done1, 16'hFFFE);
    rv1 = 4'b0001; rr1 = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("sat_reach", done1, 16'hFFFF);
    repeat (3) @(negedge clk);
    #1 chk("sat_hold", done1, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
